// File: rtl/gcd_lcm_cop.sv
// GCD/LCM coprocessor: subtractive Euclid for GCD, then a restoring divider and
// a single multiply to form LCM = (A0/g)*B0. All outputs are registered.
module gcd_lcm_cop #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic [31:0]  WDFinal,
  output logic [W-1:0] copAns,
  output logic         Busy,
  output logic         Done,
  output logic         Ovf
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [2:0] {IDLE, GCD, DIV, MUL, DONE} state_t;

  state_t          r_state;
  logic   [W-1:0]  r_a;
  logic   [W-1:0]  r_b;
  logic   [W-1:0]  r_A0;
  logic   [W-1:0]  r_B0;
  logic            r_op;
  logic   [W-1:0]  r_g;
  logic   [W-1:0]  r_q;
  logic   [W-1:0]  r_rem;
  logic   [CW-1:0] r_cnt;

  logic   [W:0]    w_remSh;
  logic   [2*W-1:0] w_prod;
  logic            w_unused;

  assign w_remSh  = {r_rem, r_q[W-1]};
  assign w_prod   = {{W{1'b0}}, r_q} * {{W{1'b0}}, r_B0};
  assign w_unused = ^WDFinal[31:2*W+1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_A0    <= '0;
      r_B0    <= '0;
      r_op    <= 1'b0;
      r_g     <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      copAns  <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_A0    <= WDFinal[W-1:0];
            r_B0    <= WDFinal[2*W-1:W];
            r_op    <= WDFinal[2*W];
            r_a     <= WDFinal[W-1:0];
            r_b     <= WDFinal[2*W-1:W];
            Busy    <= 1'b1;
            r_state <= GCD;
          end
        end
        GCD: begin
          // A zero operand would make the subtraction loop spin forever
          if (r_a == '0 || r_b == '0) begin
            copAns  <= r_op ? '0 : (r_a | r_b);
            Ovf     <= 1'b0;
            Done    <= 1'b1;
            r_state <= DONE;
          end else if (r_a > r_b) begin
            r_a <= r_a - r_b;
          end else if (r_a < r_b) begin
            r_b <= r_b - r_a;
          end else begin
            r_g <= r_a;
            if (!r_op) begin
              copAns  <= r_a;
              Ovf     <= 1'b0;
              Done    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_q     <= r_A0;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= DIV;
            end
          end
        end
        DIV: begin
          // Partial remainder stays below g, so its low W bits hold the difference
          if (w_remSh >= {1'b0, r_g}) begin
            r_rem <= w_remSh[W-1:0] - r_g;
            r_q   <= {r_q[W-2:0], 1'b1};
          end else begin
            r_rem <= w_remSh[W-1:0];
            r_q   <= {r_q[W-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) r_state <= MUL;
        end
        MUL: begin
          copAns  <= w_prod[W-1:0];
          Ovf     <= |w_prod[2*W-1:W];
          Done    <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          Busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_lcm_cop.sv
// Randomized and directed bench for gcd_lcm_cop, checked against an arithmetic
// reference model that derives results and latency from Euclid's quotients.
module tb_gcd_lcm_cop;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [31:0] WDFinal;
  logic [7:0]  copAns;
  logic        Busy;
  logic        Done;
  logic        Ovf;

  int total = 0;
  int bad   = 0;

  gcd_lcm_cop #(.W(8)) dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .WDFinal(WDFinal),
    .copAns(copAns),
    .Busy(Busy),
    .Done(Done),
    .Ovf(Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Subtractive step count equals the sum of Euclid quotients minus one
  function automatic void refModel(input int a, input int b, input int op,
                                   output int res, output int ovf, output int lat);
    int x, y, t, steps, g, l;
    if (a == 0 || b == 0) begin
      res = op ? 0 : (a | b);
      ovf = 0;
      lat = 1;
      return;
    end
    x = (a > b) ? a : b;
    y = (a > b) ? b : a;
    steps = 0;
    while (y != 0) begin
      steps += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    steps -= 1;
    g = x;
    if (op == 0) begin
      res = g;
      ovf = 0;
      lat = steps + 1;
    end else begin
      l   = (a / g) * b;
      res = l % 256;
      ovf = (l > 255) ? 1 : 0;
      lat = steps + 1 + 8 + 1;
    end
  endfunction

  task automatic applyStimulus(input int a, input int b, input int op, input int injectAt);
    int res, ovf, lat, n;
    refModel(a, b, op, res, ovf, lat);
    @(negedge clk);
    Start   = 1'b1;
    WDFinal = {15'($urandom), op[0], b[7:0], a[7:0]};
    @(posedge clk);
    #1;
    Start   = 1'b0;
    WDFinal = $urandom;
    checkOutput("busy_after_start", int'(Busy), 1);
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      Start = 1'b0;
      if (Done) break;
      if (n == injectAt) begin
        Start   = 1'b1;
        WDFinal = $urandom;
      end
    end
    checkOutput($sformatf("latency(%0d,%0d,op%0d)", a, b, op), n, lat);
    checkOutput($sformatf("copAns(%0d,%0d,op%0d)", a, b, op), int'(copAns), res);
    checkOutput($sformatf("ovf(%0d,%0d,op%0d)", a, b, op), int'(Ovf), ovf);
    @(posedge clk);
    #1;
    checkOutput("busy_clear", int'(Busy), 0);
    checkOutput("done_single", int'(Done), 0);
    checkOutput("copAns_hold", int'(copAns), res);
  endtask

  initial begin
    int sawDone;
    int a, b;
    reset   = 1'b0;
    Start   = 1'b0;
    WDFinal = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_copAns", int'(copAns), 0);
    checkOutput("reset_busy", int'(Busy), 0);
    checkOutput("reset_done", int'(Done), 0);
    checkOutput("reset_ovf", int'(Ovf), 0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(12, 18, 0, -1);
    applyStimulus(4, 6, 1, -1);
    applyStimulus(200, 3, 1, -1);
    applyStimulus(8, 8, 0, -1);
    applyStimulus(0, 9, 0, -1);
    applyStimulus(0, 9, 1, -1);
    applyStimulus(0, 0, 0, -1);
    applyStimulus(255, 1, 0, 50);

    // Abort an LCM while it is dividing
    @(negedge clk);
    Start   = 1'b1;
    WDFinal = 32'h0001_0604;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("abort_copAns", int'(copAns), 0);
    checkOutput("abort_busy", int'(Busy), 0);
    checkOutput("abort_done", int'(Done), 0);
    checkOutput("abort_ovf", int'(Ovf), 0);
    sawDone = 0;
    repeat (4) begin
      @(negedge clk);
      if (Done) sawDone = 1;
    end
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (Done || Busy) sawDone = 1;
    end
    checkOutput("abort_no_done", sawDone, 0);
    applyStimulus(21, 14, 0, -1);

    for (int i = 0; i < 25; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) a = 0;
      applyStimulus(a, b, int'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
